flag_event_sender: RTL

- Multi-channel transmit side of a toggle-based flag/ack crossing; one instance per source clock domain.
- Accepts single-cycle event pulses on NCH channels, emits one toggle per event on req_tgl, and waits for the far side's returned ack toggle before sending the next event.
- MODE selects legacy drop-while-busy behaviour or counted queuing, so events arriving during a handshake are no longer silently lost.
- Ack toggles arrive asynchronously and are synchronised internally; the peer receive block edge-detects req_tgl in its own clock domain.

---
 rtl/flag_event_sender.sv | 65 ++++++
 1 files changed

// File: rtl/flag_event_sender.sv
// flag_event_sender: multi-channel toggle-handshake event sender with ack synchronisers
module flag_event_sender #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       event_in,
    input  logic [NCH-1:0]       ack_tgl_in,
    input  logic                 clr_ovf,
    output logic [NCH-1:0]       req_tgl,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [NCH*CNT_W-1:0] pending,
    output logic [NCH-1:0]       ovf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NCH-1:0]       ackSync [SYNC_STAGES];
    logic [NCH-1:0]       busyPrev;
    logic [NCH-1:0]       launch;
    logic [NCH-1:0]       accept;
    logic [NCH*CNT_W-1:0] pendingNext;

    assign busy = req_tgl ^ ackSync[SYNC_STAGES-1];

    // Launch only from registered state; accept an event unless the queue policy forbids it.
    for (genvar c = 0; c < NCH; c++) begin : gCh
        logic [CNT_W-1:0] cnt;
        assign cnt       = pending[c*CNT_W +: CNT_W];
        assign launch[c] = (cnt != '0) & ~busy[c];
        assign accept[c] = event_in[c] & ((MODE != 0) ? ((cnt != CNT_MAX) | launch[c])
                                                      : ((cnt == '0) & ~busy[c]));
        assign pendingNext[c*CNT_W +: CNT_W] = cnt + CNT_W'(accept[c]) - CNT_W'(launch[c]);
    end

    // Multi-flop synchroniser for the asynchronous ack toggles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) ackSync[s] <= '0;
        end else begin
            ackSync[0] <= ack_tgl_in;
            for (int s = 1; s < SYNC_STAGES; s++) ackSync[s] <= ackSync[s-1];
        end
    end

    // Request toggles, pending counters, sticky overflow and handshake-complete pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_tgl  <= '0;
            pending  <= '0;
            ovf      <= '0;
            done     <= '0;
            busyPrev <= '0;
        end else begin
            req_tgl  <= req_tgl ^ launch;
            pending  <= pendingNext;
            ovf      <= (ovf & ~{NCH{clr_ovf}}) | (event_in & ~accept);
            done     <= busyPrev & ~busy;
            busyPrev <= busy;
        end
    end
endmodule
